// File: rtl/mem_port_arbiter_if.sv
// mem_port_arbiter_if: bundle of every non-clock signal around the memory
// port arbiter.
//   i_*  instruction-fetch port (read-only requester)
//   d_*  data-memory-controller port (read/write requester)
//   m_*  single-ported memory request/acknowledge bus
//   grant_data  status flag, high while the data port owns the bus
// Modports:
//   slave  - the arbiter's view (serves both requesters, drives memory bus)
//   master - the environment's view (requesters plus the memory itself)
interface mem_port_arbiter_if #(
  parameter int ADDR_W = 30
);
  logic              i_read_en;
  logic [ADDR_W-1:0] i_addr;
  logic [31:0]       i_rdata;
  logic              i_ready;

  logic              d_read_en;
  logic [3:0]        d_write_en;
  logic [ADDR_W-1:0] d_addr;
  logic [31:0]       d_wdata;
  logic [31:0]       d_rdata;
  logic              d_ready;

  logic              m_req;
  logic [3:0]        m_we;
  logic [ADDR_W-1:0] m_addr;
  logic [31:0]       m_wdata;
  logic              m_ack;
  logic [31:0]       m_rdata;
  logic              m_timeout;
  logic              grant_data;

  modport slave (
    input  i_read_en, i_addr, d_read_en, d_write_en, d_addr, d_wdata,
           m_ack, m_rdata,
    output i_rdata, i_ready, d_rdata, d_ready,
           m_req, m_we, m_addr, m_wdata, m_timeout, grant_data
  );

  modport master (
    output i_read_en, i_addr, d_read_en, d_write_en, d_addr, d_wdata,
           m_ack, m_rdata,
    input  i_rdata, i_ready, d_rdata, d_ready,
           m_req, m_we, m_addr, m_wdata, m_timeout, grant_data
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one single-ported 32-bit memory between the
// instruction-fetch port and the data-memory-controller port.
//   clock  rising-edge system clock
//   reset  asynchronous active-low reset
//   bus    mem_port_arbiter_if.slave: fetch port, data port, memory bus
// One requester is granted at a time; its command is latched on the grant
// edge and held on the memory bus until m_ack (or watchdog expiry). The
// granted port then sees a one-cycle ready pulse with its read data.
// Fetch is protected from starvation by limiting consecutive data grants
// while fetch is waiting.
module mem_port_arbiter #(
  parameter int          ADDR_W          = 30,
  parameter int          MAX_DATA_STREAK = 4,
  parameter int          TIMEOUT_CYCLES  = 255,
  parameter logic [31:0] ERR_DATA        = 32'hDEAD_BEEF
) (
  input logic               clock,
  input logic               reset,
  mem_port_arbiter_if.slave bus
);

  localparam logic [3:0] STREAK_MAX   = 4'(MAX_DATA_STREAK);
  localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {IDLE, WAIT_D, WAIT_I, RESP_D, RESP_I} state_t;

  state_t            state_reg, state_next;
  logic [3:0]        streak_reg, streak_next;
  logic [7:0]        tcnt_reg, tcnt_next;
  logic [ADDR_W-1:0] addr_reg, addr_next;
  logic [3:0]        we_reg, we_next;
  logic [31:0]       wdata_reg, wdata_next;
  logic [31:0]       i_rdata_reg, i_rdata_next;
  logic [31:0]       d_rdata_reg, d_rdata_next;
  logic              timeout_reg, timeout_next;

  logic d_req;
  logic i_req;

  // A non-zero byte mask makes the access a write regardless of d_read_en.
  assign d_req = bus.d_read_en | (|bus.d_write_en);
  assign i_req = bus.i_read_en;

  always_comb begin
    state_next   = state_reg;
    streak_next  = streak_reg;
    tcnt_next    = tcnt_reg;
    addr_next    = addr_reg;
    we_next      = we_reg;
    wdata_next   = wdata_reg;
    i_rdata_next = i_rdata_reg;
    d_rdata_next = d_rdata_reg;
    timeout_next = 1'b0;

    case (state_reg)
      IDLE: begin
        tcnt_next = '0;
        if (d_req && (!i_req || (streak_reg < STREAK_MAX))) begin
          state_next = WAIT_D;
          addr_next  = bus.d_addr;
          we_next    = bus.d_write_en;
          wdata_next = bus.d_wdata;
          // Only data grants that make fetch wait count toward the streak.
          if (!i_req) begin
            streak_next = '0;
          end else if (streak_reg != STREAK_MAX) begin
            streak_next = streak_reg + 4'd1;
          end
        end else if (i_req) begin
          state_next  = WAIT_I;
          addr_next   = bus.i_addr;
          we_next     = '0;
          wdata_next  = '0;
          streak_next = '0;
        end else begin
          streak_next = '0;
        end
      end

      WAIT_D, WAIT_I: begin
        // An ack arriving on the expiry cycle takes priority over the watchdog.
        if (bus.m_ack) begin
          if (state_reg == WAIT_D) begin
            d_rdata_next = bus.m_rdata;
            state_next   = RESP_D;
          end else begin
            i_rdata_next = bus.m_rdata;
            state_next   = RESP_I;
          end
        end else if (tcnt_reg >= TIMEOUT_LAST) begin
          timeout_next = 1'b1;
          if (state_reg == WAIT_D) begin
            d_rdata_next = ERR_DATA;
            state_next   = RESP_D;
          end else begin
            i_rdata_next = ERR_DATA;
            state_next   = RESP_I;
          end
        end else begin
          tcnt_next = tcnt_reg + 8'd1;
        end
      end

      // Requesters still hold their enables here, so no arbitration happens
      // until the following IDLE cycle.
      RESP_D, RESP_I: state_next = IDLE;

      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_reg   <= IDLE;
      streak_reg  <= '0;
      tcnt_reg    <= '0;
      addr_reg    <= '0;
      we_reg      <= '0;
      wdata_reg   <= '0;
      i_rdata_reg <= '0;
      d_rdata_reg <= '0;
      timeout_reg <= 1'b0;
    end else begin
      state_reg   <= state_next;
      streak_reg  <= streak_next;
      tcnt_reg    <= tcnt_next;
      addr_reg    <= addr_next;
      we_reg      <= we_next;
      wdata_reg   <= wdata_next;
      i_rdata_reg <= i_rdata_next;
      d_rdata_reg <= d_rdata_next;
      timeout_reg <= timeout_next;
    end
  end

  // m_req is decoded from the state register so reset removes it at once.
  assign bus.m_req      = (state_reg == WAIT_D) || (state_reg == WAIT_I);
  assign bus.m_we       = we_reg;
  assign bus.m_addr     = addr_reg;
  assign bus.m_wdata    = wdata_reg;
  assign bus.m_timeout  = timeout_reg;
  assign bus.grant_data = (state_reg == WAIT_D) || (state_reg == RESP_D);
  assign bus.i_ready    = (state_reg == RESP_I);
  assign bus.d_ready    = (state_reg == RESP_D);
  assign bus.i_rdata    = i_rdata_reg;
  assign bus.d_rdata    = d_rdata_reg;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: scoreboard bench for mem_port_arbiter.
// Requester drivers push the expected outcome of each transaction into a
// per-port queue when they issue it; a memory responder acknowledges after
// a per-transaction delay; an independent monitor pops and compares on each
// ready pulse. Expected read data comes from a shadow memory updated in
// data-port program order (fetch uses a disjoint address region).
module tb_mem_port_arbiter;
  localparam int          ADDR_W = 30;
  localparam int          MAX_S  = 4;
  localparam int          TO     = 8;
  localparam logic [31:0] ERR    = 32'hDEAD_BEEF;

  logic clock = 1'b0;
  logic reset = 1'b0;
  always #5 clock = ~clock;

  mem_port_arbiter_if #(.ADDR_W(ADDR_W)) bus();

  mem_port_arbiter #(
    .ADDR_W(ADDR_W), .MAX_DATA_STREAK(MAX_S),
    .TIMEOUT_CYCLES(TO), .ERR_DATA(ERR)
  ) dut (
    .clock(clock),
    .reset(reset),
    .bus(bus)
  );

  typedef struct {
    logic [3:0]        we;
    logic [ADDR_W-1:0] addr;
    logic [31:0]       wdata;
    logic [31:0]       rdata;
    int                k;       // wait cycles before memory acks
    bit                tmo;
    int                issue_cyc;
  } txn_t;

  txn_t d_cmd[$], i_cmd[$], d_exp[$], i_exp[$];
  bit   grant_log[$];
  logic [31:0] shadow[int];
  logic [31:0] rmem[int];
  logic [31:0] ack_data = '0;
  int   cyc = 0;
  int   n_cmp = 0;
  int   n_bad = 0;
  bit   chk_lat = 1'b0;
  bit   d_busy = 1'b0;
  bit   i_busy = 1'b0;

  always @(posedge clock) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] init_word(input int a);
    return 32'(a) * 32'h9E37_79B9 + 32'h0101_0101;
  endfunction

  function automatic logic [31:0] rd_shadow(input int a);
    return shadow.exists(a) ? shadow[a] : init_word(a);
  endfunction

  function automatic logic [31:0] rd_rmem(input int a);
    return rmem.exists(a) ? rmem[a] : init_word(a);
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw,
                                        input logic [3:0] be);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++) if (be[b]) r[8*b +: 8] = nw[8*b +: 8];
    return r;
  endfunction

  function automatic txn_t mk(input logic [3:0] we, input int addr,
                              input logic [31:0] wdata, input int k);
    txn_t t;
    t.we = we; t.addr = ADDR_W'(addr); t.wdata = wdata; t.k = k;
    t.rdata = '0; t.tmo = 1'b0; t.issue_cyc = 0;
    return t;
  endfunction

  function automatic int rand_k();
    int r;
    r = int'($urandom_range(0, 19));
    if (r < 14) return r % 4;
    if (r < 17) return TO - 1;
    return TO + 3;
  endfunction

  function automatic txn_t rand_d(input int kmax);
    logic [3:0] we;
    we = ($urandom_range(0, 2) == 0) ? 4'($urandom_range(1, 15)) : 4'd0;
    return mk(we, 32'h100 + int'($urandom_range(0, 15)), $urandom,
              (kmax < 0) ? rand_k() : int'($urandom_range(0, kmax)));
  endfunction

  function automatic txn_t rand_i(input int kmax);
    return mk(4'd0, 32'h1000 + int'($urandom_range(0, 63)), 32'd0,
              (kmax < 0) ? rand_k() : int'($urandom_range(0, kmax)));
  endfunction

  // Data requester: holds its command until d_ready, scrambles address/data
  // while granted (must be ignored), re-requests from the ready cycle.
  initial begin : d_drv
    txn_t t;
    logic [31:0] old;
    bus.d_read_en = 1'b0; bus.d_write_en = '0; bus.d_addr = '0; bus.d_wdata = '0;
    forever begin
      @(negedge clock);
      if (!reset) begin
        d_busy = 1'b0; bus.d_read_en = 1'b0; bus.d_write_en = '0;
      end else begin
        if (d_busy && bus.d_ready) d_busy = 1'b0;
        else if (d_busy && bus.m_req && bus.grant_data && $urandom_range(0, 1) == 1) begin
          bus.d_addr  = ADDR_W'($urandom);
          bus.d_wdata = $urandom;
        end
        if (!d_busy) begin
          if (d_cmd.size() > 0) begin
            t = d_cmd.pop_front();
            t.tmo = (t.k >= TO);
            t.issue_cyc = cyc;
            old = rd_shadow(int'(t.addr));
            t.rdata = t.tmo ? ERR : old;
            if (t.we != 4'd0 && !t.tmo) shadow[int'(t.addr)] = merge(old, t.wdata, t.we);
            d_exp.push_back(t);
            bus.d_addr = t.addr; bus.d_wdata = t.wdata; bus.d_write_en = t.we;
            bus.d_read_en = (t.we == 4'd0) ? 1'b1 : 1'($urandom_range(0, 1));
            d_busy = 1'b1;
          end else begin
            bus.d_read_en = 1'b0; bus.d_write_en = '0;
          end
        end
      end
    end
  end

  initial begin : i_drv
    txn_t t;
    bus.i_read_en = 1'b0; bus.i_addr = '0;
    forever begin
      @(negedge clock);
      if (!reset) begin
        i_busy = 1'b0; bus.i_read_en = 1'b0;
      end else begin
        if (i_busy && bus.i_ready) i_busy = 1'b0;
        else if (i_busy && bus.m_req && !bus.grant_data && $urandom_range(0, 1) == 1)
          bus.i_addr = ADDR_W'($urandom);
        if (!i_busy) begin
          if (i_cmd.size() > 0) begin
            t = i_cmd.pop_front();
            t.tmo = (t.k >= TO);
            t.issue_cyc = cyc;
            t.rdata = t.tmo ? ERR : rd_shadow(int'(t.addr));
            i_exp.push_back(t);
            bus.i_addr = t.addr; bus.i_read_en = 1'b1;
            i_busy = 1'b1;
          end else begin
            bus.i_read_en = 1'b0;
          end
        end
      end
    end
  end

  // Memory: acks the k-th request cycle of the current transaction; throws
  // stray acks with junk data while no request is pending.
  initial begin : responder
    int   w;
    int   k;
    int   a;
    logic [31:0] old;
    bus.m_ack = 1'b0; bus.m_rdata = '0; w = 0;
    forever begin
      @(negedge clock);
      bus.m_ack = 1'b0;
      if (!reset) begin
        w = 0;
      end else if (bus.m_req) begin
        k = 0;
        if (bus.grant_data && d_exp.size() > 0) k = d_exp[0].k;
        else if (!bus.grant_data && i_exp.size() > 0) k = i_exp[0].k;
        if (w == k) begin
          a = int'(bus.m_addr);
          old = rd_rmem(a);
          bus.m_ack = 1'b1;
          bus.m_rdata = old;
          ack_data = old;
          if (bus.m_we != 4'd0) rmem[a] = merge(old, bus.m_wdata, bus.m_we);
        end
        w++;
      end else begin
        w = 0;
        bus.m_rdata = $urandom;
        if ($urandom_range(0, 7) == 0) bus.m_ack = 1'b1;
      end
    end
  end

  initial begin : monitor
    bit   prev_req;
    int   req_cnt;
    bit   stable;
    bit   gd;
    bit   isd;
    logic [ADDR_W-1:0] a0;
    logic [3:0]  we0;
    logic [31:0] wd0;
    logic [31:0] last_i;
    logic [31:0] last_d;
    logic [31:0] exp_rd;
    txn_t e;
    prev_req = 1'b0; req_cnt = 0; stable = 1'b1; gd = 1'b0;
    a0 = '0; we0 = '0; wd0 = '0; last_i = '0; last_d = '0;
    forever begin
      @(negedge clock);
      if (!reset) begin
        prev_req = 1'b0; req_cnt = 0; last_i = '0; last_d = '0;
        continue;
      end
      if (bus.m_req) begin
        if (!prev_req) begin
          a0 = bus.m_addr; we0 = bus.m_we; wd0 = bus.m_wdata; gd = bus.grant_data;
          stable = 1'b1; req_cnt = 0;
          grant_log.push_back(gd);
          chk("grant_has_txn", (gd ? d_exp.size() : i_exp.size()) > 0, 1);
          if (gd && d_exp.size() > 0) begin
            chk("d_cmd_addr", bus.m_addr, d_exp[0].addr);
            chk("d_cmd_we", bus.m_we, d_exp[0].we);
            chk("d_cmd_wdata", bus.m_wdata, d_exp[0].wdata);
          end else if (!gd && i_exp.size() > 0) begin
            chk("i_cmd_addr", bus.m_addr, i_exp[0].addr);
            chk("i_cmd_we", bus.m_we, 4'd0);
          end
        end else if (bus.m_addr !== a0 || bus.m_we !== we0 || bus.m_wdata !== wd0 ||
                     bus.grant_data !== gd) begin
          stable = 1'b0;
        end
        req_cnt++;
      end
      if (bus.i_ready && bus.d_ready) chk("both_ready", 1, 0);
      if (bus.d_ready || bus.i_ready) begin
        isd = bus.d_ready;
        chk(isd ? "d_ready_expected" : "i_ready_expected",
            (isd ? d_exp.size() : i_exp.size()) > 0, 1);
        if ((isd ? d_exp.size() : i_exp.size()) > 0) begin
          e = isd ? d_exp.pop_front() : i_exp.pop_front();
          exp_rd = (e.we != 4'd0 && !e.tmo) ? ack_data : e.rdata;
          chk("req_cycles", req_cnt, e.tmo ? TO : e.k + 1);
          chk("ready_after_req", prev_req, 1);
          chk("req_low_at_ready", bus.m_req, 0);
          chk("cmd_stable", stable, 1);
          chk("timeout_pulse", bus.m_timeout, e.tmo);
          chk("grant_flag", bus.grant_data, isd);
          if (chk_lat) chk("latency", cyc - e.issue_cyc, e.tmo ? TO + 1 : e.k + 2);
          if (isd) begin
            chk("d_rdata", bus.d_rdata, exp_rd);
            chk("i_rdata_hold", bus.i_rdata, last_i);
            last_d = exp_rd;
          end else begin
            chk("i_rdata", bus.i_rdata, exp_rd);
            chk("d_rdata_hold", bus.d_rdata, last_d);
            last_i = exp_rd;
          end
          $display("txn %s we=%h addr=%h k=%0d tmo=%0d rdata=%h",
                   isd ? "D" : "I", e.we, e.addr, e.k, e.tmo, exp_rd);
        end
      end else if (bus.m_timeout) begin
        chk("stray_timeout", bus.m_timeout, 0);
      end
      prev_req = bus.m_req;
    end
  end

  task automatic wait_done(input int budget);
    int n;
    n = 0;
    while ((d_cmd.size() + i_cmd.size() + d_exp.size() + i_exp.size()) > 0 && n < budget) begin
      @(negedge clock);
      n++;
    end
    chk("drain_in_budget", (d_cmd.size() + i_cmd.size() + d_exp.size() + i_exp.size()) > 0, 0);
    repeat (2) @(negedge clock);
  endtask

  task automatic run_one(input bit is_d, input txn_t t);
    @(posedge clock);
    if (is_d) d_cmd.push_back(t);
    else      i_cmd.push_back(t);
    wait_done(200);
  endtask

  initial begin : watchdog
    repeat (60000) @(posedge clock);
    $display("FAIL watchdog: simulation exceeded cycle budget");
    $fatal(1, "watchdog");
  end

  initial begin : main
    int n;
    reset = 1'b0;
    repeat (3) @(negedge clock);
    chk("rst_m_req", bus.m_req, 0);
    chk("rst_m_we", bus.m_we, 0);
    chk("rst_m_addr", bus.m_addr, 0);
    chk("rst_m_wdata", bus.m_wdata, 0);
    chk("rst_i_rdata", bus.i_rdata, 0);
    chk("rst_d_rdata", bus.d_rdata, 0);
    chk("rst_i_ready", bus.i_ready, 0);
    chk("rst_d_ready", bus.d_ready, 0);
    chk("rst_m_timeout", bus.m_timeout, 0);
    chk("rst_grant_data", bus.grant_data, 0);
    @(posedge clock); #2 reset = 1'b1;

    shadow[32'h100] = 32'h1234_5678;
    rmem[32'h100]   = 32'h1234_5678;

    // Directed single transactions with exact latency checking.
    chk_lat = 1'b1;
    run_one(1'b1, mk(4'b0000, 32'h100, 32'h0, 3));
    run_one(1'b1, mk(4'b0011, 32'h104, 32'hAABB_CCDD, 0));
    run_one(1'b1, mk(4'b0000, 32'h104, 32'h0, 1));
    run_one(1'b0, mk(4'b0000, 32'h1000, 32'h0, 100));
    run_one(1'b0, mk(4'b0000, 32'h1004, 32'h0, TO - 1));
    run_one(1'b1, mk(4'b1111, 32'h108, 32'h5555_AAAA, 20));
    run_one(1'b1, mk(4'b0000, 32'h108, 32'h0, 0));
    chk_lat = 1'b0;

    // Both ports busy; reset during the third data grant's wait.
    grant_log.delete();
    @(posedge clock);
    d_cmd.push_back(mk(4'd0, 32'h110, 32'h0, 0));
    d_cmd.push_back(mk(4'd0, 32'h111, 32'h0, 0));
    d_cmd.push_back(mk(4'd0, 32'h112, 32'h0, 100));
    i_cmd.push_back(mk(4'd0, 32'h1010, 32'h0, 0));
    n = 0;
    while (grant_log.size() < 3 && n < 100) begin @(negedge clock); n++; end
    chk("pre_reset_grants", grant_log.size(), 3);
    for (int j = 0; j < 3 && j < grant_log.size(); j++) chk("pre_reset_grant_d", grant_log[j], 1);
    repeat (3) @(posedge clock);
    #2 reset = 1'b0;
    #1;
    chk("async_req_drop", bus.m_req, 0);
    chk("async_grant_drop", bus.grant_data, 0);
    for (int j = 0; j < 3; j++) begin
      @(negedge clock);
      chk("rst_no_d_ready", bus.d_ready, 0);
      chk("rst_no_i_ready", bus.i_ready, 0);
    end
    d_cmd.delete(); i_cmd.delete(); d_exp.delete(); i_exp.delete();
    @(posedge clock); #2 reset = 1'b1;

    // Continuous contention from a fresh streak: D,D,D,D,I repeating.
    grant_log.delete();
    @(posedge clock);
    for (int j = 0; j < 12; j++) d_cmd.push_back(rand_d(2));
    for (int j = 0; j < 3; j++)  i_cmd.push_back(rand_i(2));
    wait_done(2000);
    chk("fair_grant_count", grant_log.size() >= 10, 1);
    for (int j = 0; j < 10 && j < grant_log.size(); j++)
      chk("fair_grant_order", grant_log[j], (j % (MAX_S + 1)) != MAX_S);

    // Randomised traffic with gaps, timeouts and coincident acks.
    for (int j = 0; j < 400; j++) begin
      @(posedge clock);
      if ($urandom_range(0, 3) == 0 && d_cmd.size() < 3) d_cmd.push_back(rand_d(-1));
      if ($urandom_range(0, 4) == 0 && i_cmd.size() < 3) i_cmd.push_back(rand_i(-1));
    end
    wait_done(8000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one single-ported 32-bit data memory between the instruction-fetch port and the data-memory-controller port of the MIPS32 core.
- Grants one requester at a time and latches its command. It drives a request/acknowledge memory bus.
- Returns a one-cycle ready pulse plus read data to the granted port. This pulse matches the ready/RW-mask handshake the data controller already expects.
- Includes starvation protection for fetch and a watchdog timeout on the memory bus.

Parameters:
- ADDR_W, 30, word-address width (byte address bits [31:2]).
- MAX_DATA_STREAK, 4, consecutive data grants allowed while fetch is waiting; 1..15.
- TIMEOUT_CYCLES, 255, cycles of m_req without m_ack before forced completion; 1..255.
- ERR_DATA, 32'hDEAD_BEEF, read data returned on timeout.

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- i_read_en  in  1  fetch read request; held until i_ready.
- i_addr  in  ADDR_W  fetch word address.
- i_rdata  out  32  fetch read data.
- i_ready  out  1  one-cycle fetch completion pulse.
- d_read_en  in  1  data read request (controller ReadEnable).
- d_write_en  in  4  data byte write enables (controller WriteEnable).
- d_addr  in  ADDR_W  data word address.
- d_wdata  in  32  data write data.
- d_rdata  out  32  data read data.
- d_ready  out  1  one-cycle data completion pulse (to DataMem_Ready).
- m_req  out  1  memory request.
- m_we  out  4  memory byte write enables; 0 means read.
- m_addr  out  ADDR_W  memory word address.
- m_wdata  out  32  memory write data.
- m_ack  in  1  memory completion, single cycle; m_rdata is valid with it.
- m_rdata  in  32  memory read data.
- m_timeout  out  1  one-cycle pulse on watchdog expiry.
- grant_data  out  1  1 while the data port owns the bus (WAIT_D/RESP_D).

Behaviour:
- Reset (asynchronous, reset=0):
  - State is IDLE.
  - All outputs are 0, including m_req, m_we, m_addr, m_wdata, i_rdata, d_rdata and both ready pulses.
  - streak counter and timeout counter are 0.
  - Reset asserted mid-transaction abandons it immediately; no ready pulse is issued and m_req drops asynchronously.
- Data request = d_read_en | (d_write_en != 0). Fetch request = i_read_en.
  - If d_write_en != 0 the access is a write; d_read_en is ignored for that access.
- States: IDLE, WAIT_D, WAIT_I, RESP_D, RESP_I.
- IDLE arbitration, evaluated every cycle:
  - Only data requesting -> WAIT_D.
  - Only fetch requesting -> WAIT_I.
  - Both requesting -> WAIT_D if streak < MAX_DATA_STREAK, otherwise WAIT_I.
  - Neither requesting -> stay in IDLE.
- streak counter:
  - Increments on a data grant made while i_read_en=1.
  - Clears on any fetch grant, and on any IDLE cycle with i_read_en=0.
  - Saturates at MAX_DATA_STREAK.
- Grant edge:
  - m_addr, m_wdata and m_we are registered from the granted port. Fetch always uses m_we=0.
  - m_req=1 from the first WAIT cycle and is held stable until the ack cycle inclusive.
  - Requester input changes after the grant are ignored.
- WAIT_x on m_ack=1:
  - Capture m_rdata into x_rdata (writes also capture it; contents don't care).
  - Drop m_req and go to RESP_x.
- RESP_x lasts exactly one cycle, with x_ready=1, then goes to IDLE.
  - x_rdata holds its value until that port's next completion.
  - Requester enables are still high during RESP; this is the reason RESP is not an arbitration cycle.
- Latency:
  - Request seen in IDLE at cycle t -> m_req at t+1.
  - m_ack at t+1+k (k>=0) -> ready at t+2+k.
  - Minimum is 2 cycles from request to ready.
- Back-to-back:
  - After RESP the FSM returns to IDLE, so there is one idle/arbitration cycle between transactions.
  - A port re-requesting in the IDLE cycle is granted normally.
- Timeout:
  - The counter runs while in WAIT_x. When it reaches TIMEOUT_CYCLES without m_ack: drop m_req, load x_rdata=ERR_DATA, pulse m_timeout, go to RESP_x.
  - m_ack in the same cycle as expiry: ack wins, no timeout pulse.
  - The counter clears on every grant.
- m_ack while in IDLE or RESP is ignored.

Test Plan:
- Data read, addr 0x100, memory acks 3 cycles after m_req -> m_req for 4 cycles, m_we=0, d_ready single pulse one cycle after ack, d_rdata=m_rdata (0x12345678).
- Data write, d_write_en=4'b0011, d_wdata=0xAABBCCDD, immediate ack -> m_we=0011, m_wdata=0xAABBCCDD, d_ready 2 cycles after request; i_ready never pulses.
- Both ports request continuously with MAX_DATA_STREAK=4, 1-cycle ack -> grant sequence D,D,D,D,I,D,D,D,D,I; every transaction completes.
- Fetch request, memory never acks, TIMEOUT_CYCLES=8 -> m_req low after 8 cycles, m_timeout pulse, i_ready pulse with i_rdata=0xDEADBEEF; next case has ack coincident with expiry -> real data returned, no m_timeout.
- Reset pulled low while in WAIT_D -> m_req=0 immediately, no d_ready; after release, a new data read completes normally with streak=0.
- Data request changes d_addr mid-WAIT -> m_addr stays at the granted value; requester holds enable through the RESP cycle and no duplicate grant occurs.
